// File: rtl/tour_cmd_sequencer.sv
// Tour command sequencer.
// In idle it forwards host (UART) commands straight through to cmd_proc.
// Once the solver reports a solved tour, it takes over the cmd_proc interface.
// It then replays each L-move as two legs:
//   - a vertical leg issued as a plain move;
//   - a horizontal leg issued as a move with fanfare.
// It also chooses the response byte the host sees after every cmd_proc move.

module tour_cmd_sequencer #(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp,
    output logic        tour_err
);

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        HOLD_V,
        HORZ,
        HOLD_H
    } state_t;

    localparam logic [3:0] OP_MOVE     = 4'h2;
    localparam logic [3:0] OP_FANFARE  = 4'h3;
    localparam logic [7:0] HEAD_NORTH  = 8'h00;
    localparam logic [7:0] HEAD_WEST   = 8'h3F;
    localparam logic [7:0] HEAD_SOUTH  = 8'h7F;
    localparam logic [7:0] HEAD_EAST   = 8'hBF;
    localparam logic [7:0] RESP_MID    = 8'h5A;
    localparam logic [7:0] RESP_DONE   = 8'hA5;
    localparam logic [4:0] LAST_IDX    = 5'(NUM_MOVES - 1);

    state_t      state_q, state_d;
    logic [4:0]  mvIndx_q, mvIndx_d;

    logic        moveOneHot;
    logic        lastMove;
    logic        dxNeg, dyNeg;
    logic [1:0]  dxMag, dyMag;
    logic [15:0] vertCmd, horzCmd;

    // Split the one-hot L-move into sign and magnitude of each axis.
    always_comb begin
        dxNeg = 1'b0;
        dxMag = 2'd0;
        dyNeg = 1'b0;
        dyMag = 2'd0;
        case (move)
            8'b0000_0001: begin dxNeg = 1'b0; dxMag = 2'd1; dyNeg = 1'b0; dyMag = 2'd2; end
            8'b0000_0010: begin dxNeg = 1'b1; dxMag = 2'd1; dyNeg = 1'b0; dyMag = 2'd2; end
            8'b0000_0100: begin dxNeg = 1'b1; dxMag = 2'd2; dyNeg = 1'b0; dyMag = 2'd1; end
            8'b0000_1000: begin dxNeg = 1'b1; dxMag = 2'd2; dyNeg = 1'b1; dyMag = 2'd1; end
            8'b0001_0000: begin dxNeg = 1'b1; dxMag = 2'd1; dyNeg = 1'b1; dyMag = 2'd2; end
            8'b0010_0000: begin dxNeg = 1'b0; dxMag = 2'd1; dyNeg = 1'b1; dyMag = 2'd2; end
            8'b0100_0000: begin dxNeg = 1'b0; dxMag = 2'd2; dyNeg = 1'b1; dyMag = 2'd1; end
            8'b1000_0000: begin dxNeg = 1'b0; dxMag = 2'd2; dyNeg = 1'b0; dyMag = 2'd1; end
            default:      begin dxNeg = 1'b0; dxMag = 2'd0; dyNeg = 1'b0; dyMag = 2'd0; end
        endcase
    end

    // Build both leg commands and the tour-status flags from the current move.
    always_comb begin
        moveOneHot = (move != 8'd0) && ((move & (move - 8'd1)) == 8'd0);
        lastMove   = (mvIndx_q == LAST_IDX);
        vertCmd    = {OP_MOVE,    (dyNeg ? HEAD_SOUTH : HEAD_NORTH), 2'b00, dyMag};
        horzCmd    = {OP_FANFARE, (dxNeg ? HEAD_WEST  : HEAD_EAST),  2'b00, dxMag};
    end

    // Register the sequencer state and the replay index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mvIndx_q <= 5'd0;
        end else begin
            state_q  <= state_d;
            mvIndx_q <= mvIndx_d;
        end
    end

    // Choose the next state and drive the cmd_proc and host-side outputs.
    always_comb begin
        state_d          = state_q;
        mvIndx_d         = mvIndx_q;
        cmd              = cmd_UART;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = RESP_MID;
        tour_err         = 1'b0;
        case (state_q)
            IDLE: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
                resp             = RESP_DONE;
                if (start_tour) begin
                    mvIndx_d = 5'd0;
                    state_d  = VERT;
                end
            end
            VERT: begin
                cmd = vertCmd;
                if (!moveOneHot) begin
                    tour_err = 1'b1;
                    mvIndx_d = 5'd0;
                    state_d  = IDLE;
                end else begin
                    cmd_rdy = 1'b1;
                    if (clr_cmd_rdy) begin
                        state_d = HOLD_V;
                    end
                end
            end
            HOLD_V: begin
                cmd  = vertCmd;
                resp = RESP_MID;
                if (send_resp) begin
                    state_d = HORZ;
                end
            end
            HORZ: begin
                cmd     = horzCmd;
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) begin
                    state_d = HOLD_H;
                end
            end
            HOLD_H: begin
                cmd  = horzCmd;
                resp = lastMove ? RESP_DONE : RESP_MID;
                if (send_resp) begin
                    if (lastMove) begin
                        mvIndx_d = 5'd0;
                        state_d  = IDLE;
                    end else begin
                        mvIndx_d = mvIndx_q + 5'd1;
                        state_d  = VERT;
                    end
                end
            end
            default: begin
                mvIndx_d = 5'd0;
                state_d  = IDLE;
            end
        endcase
    end

    assign mv_indx = mvIndx_q;

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Self-checking bench for tour_cmd_sequencer.
// A tiny cmd_proc model acknowledges every command the sequencer raises.
// Expected commands and responses are queued when stimulus is set up,
// and each one is consumed as the sequencer actually produces it.

module tb_tour_cmd_sequencer;

    localparam int NUM_MOVES = 24;

    logic        clk;
    logic        rst_n;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        tour_err;

    // Solver move memory, read combinationally at the replay index
    logic [7:0]  moveMem [0:NUM_MOVES-1];

    // Scoreboard queues for commands and the response byte after each leg
    logic [15:0] cmdQ [$];
    logic [7:0]  respQ [$];

    int numChecks = 0;
    int numErrors = 0;

    tour_cmd_sequencer #(.NUM_MOVES(NUM_MOVES)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_tour       (start_tour),
        .move             (move),
        .mv_indx          (mv_indx),
        .cmd_UART         (cmd_UART),
        .cmd_rdy_UART     (cmd_rdy_UART),
        .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .send_resp        (send_resp),
        .resp             (resp),
        .tour_err         (tour_err)
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Solver memory is combinational, so the move follows mv_indx directly
    assign move = moveMem[mv_indx];

    // Compare one observed value against its expectation and tally the result
    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numErrors++;
            $display("[TB] FAIL %s: got %h, expected %h at time %0t", tag, actual, expected, $time);
        end
    endtask

    // Advance to just after the next rising edge, where outputs are stable
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-written vertical leg for each one-hot move
    function automatic logic [15:0] vertModel(input logic [7:0] m);
        case (m)
            8'h01: return 16'h2002;
            8'h02: return 16'h2002;
            8'h04: return 16'h2001;
            8'h08: return 16'h27F1;
            8'h10: return 16'h27F2;
            8'h20: return 16'h27F2;
            8'h40: return 16'h27F1;
            8'h80: return 16'h2001;
            default: return 16'hxxxx;
        endcase
    endfunction

    // Hand-written horizontal leg for each one-hot move
    function automatic logic [15:0] horzModel(input logic [7:0] m);
        case (m)
            8'h01: return 16'h3BF1;
            8'h02: return 16'h33F1;
            8'h04: return 16'h33F2;
            8'h08: return 16'h33F2;
            8'h10: return 16'h33F1;
            8'h20: return 16'h3BF1;
            8'h40: return 16'h3BF2;
            8'h80: return 16'h3BF2;
            default: return 16'hxxxx;
        endcase
    endfunction

    // Queue every leg of a full tour with the response the host should see
    task automatic pushTour();
        for (int i = 0; i < NUM_MOVES; i++) begin
            cmdQ.push_back(vertModel(moveMem[i]));
            respQ.push_back(8'h5A);
            cmdQ.push_back(horzModel(moveMem[i]));
            respQ.push_back((i == NUM_MOVES - 1) ? 8'hA5 : 8'h5A);
        end
    endtask

    // Throw away whatever a cut-short tour left in the scoreboard
    task automatic clearScoreboard();
        cmdQ.delete();
        respQ.delete();
    endtask

    // One-cycle start_tour pulse from the solver
    task automatic applyStimulus();
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
    endtask

    // Act as cmd_proc for one command.
    // Wait for cmd_rdy, then check the command, ack it,
    // and optionally finish the move with send_resp.
    task automatic serviceLeg(input bit doResp, input logic expUartClr);
        int waitCycles;
        logic [15:0] expCmd;
        logic [7:0]  expResp;
        waitCycles = 0;
        while (cmd_rdy !== 1'b1 && waitCycles < 40) begin
            tick();
            waitCycles++;
        end
        if (cmd_rdy !== 1'b1) begin
            checkOutput("cmdRdyWait", {15'd0, cmd_rdy}, 16'd1);
            return;
        end
        expCmd = (cmdQ.size() != 0) ? cmdQ.pop_front() : 16'hxxxx;
        checkOutput("cmd", cmd, expCmd);
        clr_cmd_rdy = 1'b1;
        #1;
        checkOutput("clrCmdRdyUart", {15'd0, clr_cmd_rdy_UART}, {15'd0, expUartClr});
        tick();
        clr_cmd_rdy = 1'b0;
        if (expUartClr) cmd_rdy_UART = 1'b0;
        #1;
        checkOutput("cmdRdyAfterAck", {15'd0, cmd_rdy}, 16'd0);
        if (doResp) begin
            repeat (2) tick();
            send_resp = 1'b1;
            #1;
            expResp = (respQ.size() != 0) ? respQ.pop_front() : 8'hxx;
            checkOutput("resp", {8'd0, resp}, {8'd0, expResp});
            tick();
            send_resp = 1'b0;
        end
    endtask

    // Main sequence: reset, idle pass-through, full tours, arbitration, bad move, mid-tour reset
    initial begin
        rst_n        = 1'b0;
        start_tour   = 1'b0;
        cmd_UART     = 16'h1234;
        cmd_rdy_UART = 1'b0;
        clr_cmd_rdy  = 1'b0;
        send_resp    = 1'b0;
        for (int i = 0; i < NUM_MOVES; i++) moveMem[i] = 8'h01 << ((i * 3) % 8);

        // Reset state
        repeat (2) tick();
        checkOutput("rstMvIndx", {11'd0, mv_indx}, 16'd0);
        checkOutput("rstTourErr", {15'd0, tour_err}, 16'd0);
        checkOutput("rstResp", {8'd0, resp}, 16'h00A5);
        checkOutput("rstCmd", cmd, 16'h1234);
        checkOutput("rstCmdRdy", {15'd0, cmd_rdy}, 16'd0);
        rst_n = 1'b1;
        tick();

        // Idle pass-through of a host command
        cmd_UART     = 16'h2002;
        cmd_rdy_UART = 1'b1;
        cmdQ.push_back(16'h2002);
        respQ.push_back(8'hA5);
        #1;
        serviceLeg(1'b1, 1'b1);

        // Single L-move followed by the rest of a full tour
        pushTour();
        applyStimulus();
        for (int leg = 0; leg < 2 * NUM_MOVES; leg++) begin
            serviceLeg(1'b1, 1'b0);
            if (leg == 1) checkOutput("mvIndxAfterFirst", {11'd0, mv_indx}, 16'd1);
        end
        checkOutput("tourEndMvIndx", {11'd0, mv_indx}, 16'd0);
        checkOutput("tourEndCmd", cmd, cmd_UART);
        checkOutput("tourEndQueue", 16'(cmdQ.size()), 16'd0);

        // start_tour and a pending host command in the same cycle
        pushTour();
        cmd_UART     = 16'h2AB1;
        cmdQ.push_back(16'h2AB1);
        respQ.push_back(8'hA5);
        cmd_rdy_UART = 1'b1;
        applyStimulus();
        for (int leg = 0; leg < 2 * NUM_MOVES; leg++) serviceLeg(1'b1, 1'b0);
        serviceLeg(1'b1, 1'b1);
        checkOutput("arbQueue", 16'(cmdQ.size()), 16'd0);

        // Non-one-hot move at index 5 aborts the tour
        moveMem[5] = 8'h03;
        pushTour();
        applyStimulus();
        for (int leg = 0; leg < 10; leg++) serviceLeg(1'b1, 1'b0);
        checkOutput("badMvIndx", {11'd0, mv_indx}, 16'd5);
        checkOutput("badTourErr", {15'd0, tour_err}, 16'd1);
        checkOutput("badCmdRdy", {15'd0, cmd_rdy}, 16'd0);
        tick();
        checkOutput("badTourErrPulse", {15'd0, tour_err}, 16'd0);
        checkOutput("badMvIndxClr", {11'd0, mv_indx}, 16'd0);
        repeat (3) tick();
        checkOutput("badCmdRdyIdle", {15'd0, cmd_rdy}, 16'd0);
        checkOutput("badCmdIdle", cmd, cmd_UART);
        clearScoreboard();
        moveMem[5] = 8'h01 << 7;

        // Reset while holding the horizontal leg of move 10
        pushTour();
        applyStimulus();
        for (int leg = 0; leg < 21; leg++) serviceLeg(1'b1, 1'b0);
        serviceLeg(1'b0, 1'b0);
        checkOutput("holdMvIndx", {11'd0, mv_indx}, 16'd10);
        rst_n        = 1'b0;
        cmd_UART     = 16'h3123;
        cmd_rdy_UART = 1'b1;
        tick();
        checkOutput("midRstMvIndx", {11'd0, mv_indx}, 16'd0);
        checkOutput("midRstCmd", cmd, 16'h3123);
        checkOutput("midRstCmdRdy", {15'd0, cmd_rdy}, 16'd1);
        rst_n        = 1'b1;
        cmd_rdy_UART = 1'b0;
        clearScoreboard();
        tick();
        pushTour();
        applyStimulus();
        checkOutput("restartMvIndx", {11'd0, mv_indx}, 16'd0);
        serviceLeg(1'b1, 1'b0);
        serviceLeg(1'b1, 1'b0);
        checkOutput("restartMvIndxNext", {11'd0, mv_indx}, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule
